// File: rtl/calib_pkg.sv
// Shared types and constants for the LED calibration bit sequencer and its RMW storage.
package calib_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHOW_BIT,
    WAIT_VALID,
    SETTLE,
    WAIT_FRAME,
    CAPTURE,
    DONE
  } calib_seq_state_t;

  localparam int unsigned RAM_READ_LATENCY = 2;

  // Width helper that never collapses to zero bits for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/calib_rmw_ram.sv
// Simple dual-port block RAM: registered two-stage read port and a write port that
// stores the supplied old word shifted left by one with a new LSB appended.
module calib_rmw_ram
  import calib_pkg::*;
#(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned DEPTH      = 3600,
  parameter int unsigned ADDR_WIDTH = clog2_min1(DEPTH)
) (
  input  logic                  clk_pixel,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_word,
  input  logic                  wr_bit
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q;

  // No reset: contents survive rst so results can be read back after a run.
  always_ff @(posedge clk_pixel) begin
    if (wr_en) begin
      mem[wr_addr] <= {wr_word[WIDTH-2:0], wr_bit};
    end
    if (rd_en) begin
      rd_q <= mem[rd_addr];
    end
    rd_data <= rd_q;
  end

endmodule

// File: rtl/calib_bit_sequencer.sv
// Steps through LED id bits MSB first: requests each pattern, waits for display and settle,
// then captures one frame, shifting the selected detector bit into a per-block RAM word.
module calib_bit_sequencer
  import calib_pkg::*;
#(
  parameter int unsigned LED_ADDRESS_WIDTH = 10,
  parameter int unsigned WAIT_CYCLES       = 10000000,
  parameter int unsigned ACTIVE_H_PIXELS   = 320,
  parameter int unsigned ACTIVE_LINES      = 180,
  parameter int unsigned DOWNSAMPLE_SHIFT  = 2,
  parameter int unsigned DETECT_CHANNELS   = 2,
  localparam int unsigned DEPTH  = (ACTIVE_H_PIXELS >> DOWNSAMPLE_SHIFT) *
                                   (ACTIVE_LINES >> DOWNSAMPLE_SHIFT),
  localparam int unsigned BIT_W  = clog2_min1(LED_ADDRESS_WIDTH),
  localparam int unsigned SEL_W  = clog2_min1(DETECT_CHANNELS),
  localparam int unsigned ADDR_W = clog2_min1(DEPTH)
) (
  input  logic                         clk_pixel,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [10:0]                  hcount_in,
  input  logic [9:0]                   vcount_in,
  input  logic                         new_frame_in,
  input  logic [DETECT_CHANNELS-1:0]   detect_in,
  input  logic [SEL_W-1:0]             detect_sel,
  output logic                         pattern_req_out,
  output logic [BIT_W-1:0]             bit_index_out,
  input  logic                         displayed_frame_valid,
  output calib_seq_state_t             state,
  output logic                         busy_out,
  output logic                         done_out,
  input  logic                         read_req_in,
  input  logic [ADDR_W-1:0]            read_addr_in,
  output logic                         read_valid_out,
  output logic [LED_ADDRESS_WIDTH-1:0] read_data_out
);

  localparam int unsigned H_BLOCKS = ACTIVE_H_PIXELS >> DOWNSAMPLE_SHIFT;
  localparam int unsigned CNT_W    = clog2_min1(WAIT_CYCLES);
  localparam int unsigned LAT      = RAM_READ_LATENCY;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_MSB     = BIT_W'(LED_ADDRESS_WIDTH - 1);
  localparam logic [10:0]      H_LOW_MASK  = 11'((1 << DOWNSAMPLE_SHIFT) - 1);
  localparam logic [9:0]       V_LOW_MASK  = 10'((1 << DOWNSAMPLE_SHIFT) - 1);

  calib_seq_state_t state_d;

  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q;
  logic             start_rise;

  logic              in_region;
  logic              sample;
  logic [ADDR_W-1:0] sample_addr;
  logic              ext_rd;

  logic [LAT-1:0]    rmw_vld_q;
  logic [LAT-1:0]    rmw_bit_q;
  logic [ADDR_W-1:0] rmw_addr_q [LAT];
  logic [LAT-1:0]    ext_vld_q;

  logic                         ram_rd_en;
  logic [ADDR_W-1:0]            ram_rd_addr;
  logic [LED_ADDRESS_WIDTH-1:0] ram_rd_data;
  logic                         ram_wr_en;

  assign start_rise = start && !start_q;

  assign in_region = (32'(hcount_in) < ACTIVE_H_PIXELS) && (32'(vcount_in) < ACTIVE_LINES) &&
                     ((hcount_in & H_LOW_MASK) == '0) && ((vcount_in & V_LOW_MASK) == '0);

  // A frame boundary wins over a coincident sample; abort kills new samples immediately.
  assign sample = (state == CAPTURE) && !new_frame_in && !abort && in_region;

  assign sample_addr = ADDR_W'(32'(hcount_in >> DOWNSAMPLE_SHIFT) +
                               H_BLOCKS * 32'(vcount_in >> DOWNSAMPLE_SHIFT));

  assign busy_out        = (state != IDLE) && (state != DONE);
  assign done_out        = (state == DONE);
  assign pattern_req_out = (state == SHOW_BIT);
  assign bit_index_out   = bit_idx_q;

  // Host reads only run while idle, so they never collide with capture samples.
  assign ext_rd      = read_req_in && !busy_out && (32'(read_addr_in) < DEPTH);
  assign ram_rd_en   = sample || ext_rd;
  assign ram_rd_addr = sample ? sample_addr : read_addr_in;
  assign ram_wr_en   = rmw_vld_q[LAT-1] && !abort && !rst;

  assign read_valid_out = ext_vld_q[LAT-1];
  assign read_data_out  = ram_rd_data;

  always_comb begin
    state_d   = state;
    bit_idx_d = bit_idx_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_rise) begin
            sel_d     = detect_sel;
            bit_idx_d = BIT_MSB;
            state_d   = SHOW_BIT;
          end
        end
        SHOW_BIT: state_d = WAIT_VALID;
        WAIT_VALID: begin
          if (displayed_frame_valid) begin
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = WAIT_FRAME;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_FRAME: begin
          if (new_frame_in) begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (new_frame_in) begin
            if (bit_idx_q == '0) begin
              state_d = DONE;
            end else begin
              bit_idx_d = bit_idx_q - BIT_W'(1);
              state_d   = SHOW_BIT;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx_q <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
    end else begin
      state     <= state_d;
      bit_idx_q <= bit_idx_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      start_q   <= start;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (rst || abort) begin
      rmw_vld_q <= '0;
    end else begin
      rmw_vld_q <= {rmw_vld_q[LAT-2:0], sample};
    end
    if (rst) begin
      ext_vld_q <= '0;
    end else begin
      ext_vld_q <= {ext_vld_q[LAT-2:0], ext_rd};
    end
  end

  // Address and detector bit ride alongside the read so the write lands when old data returns.
  always_ff @(posedge clk_pixel) begin
    rmw_addr_q[0] <= sample_addr;
    for (int unsigned i = 1; i < LAT; i++) begin
      rmw_addr_q[i] <= rmw_addr_q[i-1];
    end
    rmw_bit_q <= {rmw_bit_q[LAT-2:0], detect_in[sel_q]};
  end

  calib_rmw_ram #(
    .WIDTH      (LED_ADDRESS_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_W)
  ) u_ram (
    .clk_pixel (clk_pixel),
    .rd_en     (ram_rd_en),
    .rd_addr   (ram_rd_addr),
    .rd_data   (ram_rd_data),
    .wr_en     (ram_wr_en),
    .wr_addr   (rmw_addr_q[LAT-1]),
    .wr_word   (ram_rd_data),
    .wr_bit    (rmw_bit_q[LAT-1])
  );

endmodule

// File: tb/tb_calib_bit_sequencer.sv
// Bench for calib_bit_sequencer: small 16x8 raster, random detector maps, expected RAM
// words built from the per-bit detector values of each run.
module tb_calib_bit_sequencer;
  import calib_pkg::*;

  localparam int W     = 4;
  localparam int WAITC = 8;
  localparam int HA    = 16;
  localparam int LA    = 8;
  localparam int S     = 2;
  localparam int DC    = 2;
  localparam int DEPTH = (HA >> S) * (LA >> S);
  localparam int HT    = 24;
  localparam int VT    = 12;

  logic             clk_pixel = 1'b0;
  logic             rst, start, abort;
  logic [10:0]      hcount_in;
  logic [9:0]       vcount_in;
  logic             new_frame_in;
  logic [DC-1:0]    detect_in;
  logic [0:0]       detect_sel;
  logic             pattern_req_out;
  logic [1:0]       bit_index_out;
  logic             displayed_frame_valid;
  calib_seq_state_t state;
  logic             busy_out, done_out;
  logic             read_req_in;
  logic [2:0]       read_addr_in;
  logic             read_valid_out;
  logic [W-1:0]     read_data_out;

  int total, bad, pat_cnt, cur_bit;
  logic       dv [DC][W][DEPTH];
  logic [3:0] exp_mem [DEPTH];
  logic [3:0] old_mem [DEPTH];

  calib_bit_sequencer #(
    .LED_ADDRESS_WIDTH (W),
    .WAIT_CYCLES       (WAITC),
    .ACTIVE_H_PIXELS   (HA),
    .ACTIVE_LINES      (LA),
    .DOWNSAMPLE_SHIFT  (S),
    .DETECT_CHANNELS   (DC)
  ) dut (
    .clk_pixel             (clk_pixel),
    .rst                   (rst),
    .start                 (start),
    .abort                 (abort),
    .hcount_in             (hcount_in),
    .vcount_in             (vcount_in),
    .new_frame_in          (new_frame_in),
    .detect_in             (detect_in),
    .detect_sel            (detect_sel),
    .pattern_req_out       (pattern_req_out),
    .bit_index_out         (bit_index_out),
    .displayed_frame_valid (displayed_frame_valid),
    .state                 (state),
    .busy_out              (busy_out),
    .done_out              (done_out),
    .read_req_in           (read_req_in),
    .read_addr_in          (read_addr_in),
    .read_valid_out        (read_valid_out),
    .read_data_out         (read_data_out)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Raster source: new_frame on the last blanking pixel, detector map on block corners, noise elsewhere.
  initial begin
    int hc, vc, a;
    hc = 0; vc = 0; cur_bit = 0;
    hcount_in = '0; vcount_in = '0; new_frame_in = 1'b0; detect_in = '0;
    forever begin
      @(negedge clk_pixel);
      if (hc == HT - 1) begin
        hc = 0;
        vc = (vc == VT - 1) ? 0 : vc + 1;
      end else begin
        hc++;
      end
      hcount_in    = 11'(hc);
      vcount_in    = 10'(vc);
      new_frame_in = (hc == HT - 1) && (vc == VT - 1);
      if (hc < HA && vc < LA && hc % 4 == 0 && vc % 4 == 0) begin
        a = hc / 4 + (HA / 4) * (vc / 4);
        detect_in = {dv[1][cur_bit][a], dv[0][cur_bit][a]};
      end else begin
        detect_in = 2'($urandom);
      end
    end
  end

  initial begin
    pat_cnt = 0;
    forever begin
      @(negedge clk_pixel);
      if (pattern_req_out === 1'b1) pat_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fill_random();
    for (int c = 0; c < DC; c++)
      for (int k = 0; k < W; k++)
        for (int a = 0; a < DEPTH; a++) dv[c][k][a] = 1'($urandom);
  endtask

  // Word after a complete run: bit k holds the selected channel's value in bit k's frame.
  task automatic exp_full(input int sel);
    for (int a = 0; a < DEPTH; a++) begin
      logic [3:0] w;
      w = '0;
      for (int k = 0; k < W; k++) if (dv[sel][k][a]) w = w | (4'(1) << k);
      exp_mem[a] = w;
    end
  endtask

  task automatic wait_state(input calib_seq_state_t s, input int limit, input string tag);
    int n;
    n = 0;
    while (state !== s && n < limit) begin
      @(negedge clk_pixel);
      n++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic wait_pattern(input int b);
    int n;
    n = 0;
    while (pattern_req_out !== 1'b1 && n < 3000) begin
      @(negedge clk_pixel);
      n++;
    end
    chk($sformatf("pattern_b%0d", b), 32'(pattern_req_out), 32'(1));
  endtask

  task automatic rd_chk(input int addr, input logic [3:0] expv, input string tag);
    read_addr_in = 3'(addr);
    read_req_in  = 1'b1;
    @(negedge clk_pixel);
    read_req_in = 1'b0;
    chk($sformatf("%s_a%0d_early", tag, addr), 32'(read_valid_out), 32'(0));
    @(negedge clk_pixel);
    chk($sformatf("%s_a%0d_valid", tag, addr), 32'(read_valid_out), 32'(1));
    chk($sformatf("%s_a%0d_data", tag, addr), 32'(read_data_out), 32'(expv));
    @(negedge clk_pixel);
  endtask

  task automatic rd_none(input int addr, input string tag);
    read_addr_in = 3'(addr);
    read_req_in  = 1'b1;
    @(negedge clk_pixel);
    read_req_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_novalid%0d", tag, i), 32'(read_valid_out), 32'(0));
      @(negedge clk_pixel);
    end
  endtask

  task automatic rd_all(input string tag);
    for (int a = 0; a < DEPTH; a++) rd_chk(a, exp_mem[a], tag);
  endtask

  task automatic do_run(input int sel_start, input int sel_mid, input bit hold_start,
                        input int dfv_wait, input bit toggle_start, input bit read_in_settle,
                        input int abort_bit);
    int n;
    detect_sel = 1'(sel_start);
    start      = 1'b1;
    pat_cnt    = 0;
    @(negedge clk_pixel);
    if (!hold_start) start = 1'b0;
    for (int b = W - 1; b >= 0; b--) begin
      wait_pattern(b);
      cur_bit = b;
      if (b == W - 1) detect_sel = 1'(sel_mid);
      if (toggle_start) begin
        start = 1'b1;
        @(negedge clk_pixel);
        start = 1'b0;
      end
      repeat (dfv_wait) @(negedge clk_pixel);
      chk($sformatf("wait_valid_b%0d", b), 32'(state), 32'(WAIT_VALID));
      displayed_frame_valid = 1'b1;
      @(negedge clk_pixel);
      displayed_frame_valid = 1'b0;
      chk($sformatf("busy_b%0d", b), 32'(busy_out), 32'(1));
      if (read_in_settle && b == W - 1) begin
        chk("settle_state", 32'(state), 32'(SETTLE));
        rd_none(5, "settle_read");
      end
      if (b == abort_bit) begin
        wait_state(CAPTURE, 1000, "abort_reach_capture");
        n = 0;
        while (vcount_in != 10'd9 && n < 1000) begin
          @(negedge clk_pixel);
          n++;
        end
        abort = 1'b1;
        @(negedge clk_pixel);
        chk("abort_state", 32'(state), 32'(IDLE));
        chk("abort_busy", 32'(busy_out), 32'(0));
        chk("abort_done", 32'(done_out), 32'(0));
        abort = 1'b0;
        return;
      end
    end
    wait_state(DONE, 3000, "run_done_state");
    chk("run_done_out", 32'(done_out), 32'(1));
    chk("run_busy_low", 32'(busy_out), 32'(0));
    chk("run_pattern_count", 32'(pat_cnt), 32'(W));
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; detect_sel = '0;
    displayed_frame_valid = 1'b0; read_req_in = 1'b0; read_addr_in = '0;
    for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;
    repeat (3) @(negedge clk_pixel);
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_bit_index", 32'(bit_index_out), 32'(0));
    chk("rst_pattern", 32'(pattern_req_out), 32'(0));
    chk("rst_busy", 32'(busy_out), 32'(0));
    chk("rst_done", 32'(done_out), 32'(0));
    chk("rst_read_valid", 32'(read_valid_out), 32'(0));
    rst = 1'b0;
    @(negedge clk_pixel);

    // Full run on channel 0, pixel (4,4) lit only for bits 3 and 1, slow display handshake.
    fill_random();
    dv[0][3][5] = 1'b1; dv[0][2][5] = 1'b0; dv[0][1][5] = 1'b1; dv[0][0][5] = 1'b0;
    do_run(0, 0, 1'b0, 100, 1'b0, 1'b0, -1);
    exp_full(0);
    rd_chk(5, 4'b1010, "px44");
    rd_all("run1");

    // Channel 1 latched at start, select changed mid-run, start pulses while busy, read in SETTLE.
    fill_random();
    do_run(1, 0, 1'b0, 3, 1'b1, 1'b1, -1);
    exp_full(1);
    rd_chk(5, exp_mem[5], "done_read");
    rd_all("run2");

    // Start raised in DONE and held: one run only.
    fill_random();
    do_run(0, 0, 1'b1, 2, 1'b0, 1'b0, -1);
    repeat (50) @(negedge clk_pixel);
    chk("held_start_state", 32'(state), 32'(DONE));
    chk("held_start_patterns", 32'(pat_cnt), 32'(W));
    start = 1'b0;
    exp_full(0);
    rd_all("run3");

    // Abort in bit 2 capture after the frame's samples: words hold two new bits, then frozen.
    for (int a = 0; a < DEPTH; a++) old_mem[a] = exp_mem[a];
    fill_random();
    do_run(1, 1, 1'b0, 2, 1'b0, 1'b0, 2);
    for (int a = 0; a < DEPTH; a++)
      exp_mem[a] = 4'(((int'(old_mem[a]) << 2) | (int'(dv[1][3][a]) << 1) | int'(dv[1][2][a])) & 15);
    repeat (600) @(negedge clk_pixel);
    chk("post_abort_idle", 32'(state), 32'(IDLE));
    rd_all("abort");

    // Reset mid-run together with abort and start: back to IDLE, RAM untouched.
    fill_random();
    detect_sel = 1'b0; start = 1'b1; pat_cnt = 0;
    @(negedge clk_pixel);
    start = 1'b0;
    wait_pattern(W - 1);
    cur_bit = W - 1;
    repeat (2) @(negedge clk_pixel);
    displayed_frame_valid = 1'b1;
    @(negedge clk_pixel);
    displayed_frame_valid = 1'b0;
    chk("pre_rst_settle", 32'(state), 32'(SETTLE));
    rst = 1'b1; abort = 1'b1; start = 1'b1;
    @(negedge clk_pixel);
    chk("midrst_state", 32'(state), 32'(IDLE));
    chk("midrst_bit_index", 32'(bit_index_out), 32'(0));
    chk("midrst_busy", 32'(busy_out), 32'(0));
    chk("midrst_pattern", 32'(pattern_req_out), 32'(0));
    rst = 1'b0; abort = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk_pixel);
    chk("post_rst_idle", 32'(state), 32'(IDLE));
    rd_all("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
